gost89_ecb_engine: RTL and testbench

- Iterative GOST 28147-89 block cipher in ECB mode. Processes one 64-bit block per operation at one Feistel round per clock, 32 rounds per block.
- A `mode` input selects encryption or decryption. S-box table and 256-bit key are supplied as wide static inputs.
- Sits between a data-path controller that issues `load_data` pulses and downstream logic that consumes `out` when `busy` is low.

---
 rtl/gost89_ecb_engine.sv | 119 +++++++++++
 tb/tb_gost89_ecb_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gost89_ecb_engine.sv
// Iterative GOST 28147-89 ECB engine: one Feistel round per clock, 32 rounds per block.
// A load starts an operation, and the result appears in `out` 33 clocks after the load.
module gost89_ecb_engine (
  input  logic         clk,
  input  logic         reset,
  input  logic         mode,
  input  logic         load_data,
  input  logic [511:0] sbox,
  input  logic [255:0] key,
  input  logic [63:0]  in,
  output logic [63:0]  out,
  output logic         busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  counter_reg, counter_next;
  logic [31:0] n1_reg, n1_next;
  logic [31:0] n2_reg, n2_next;
  logic        mode_reg, mode_next;
  logic [63:0] out_reg, out_next;

  logic [31:0] subkey [8];
  logic [3:0]  sbox_tab [8][16];
  logic [4:0]  round_idx;
  logic [2:0]  key_idx;
  logic [31:0] round_key;
  logic [31:0] sum_word;
  logic [31:0] sub_word;
  logic [31:0] f_word;
  logic        fwd_order;

  // Unpack the wide static inputs into indexable tables.
  for (genvar gi = 0; gi < 8; gi++) begin : g_subkey
    assign subkey[gi] = key[255-32*gi -: 32];
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_sbox_row
    for (genvar gj = 0; gj < 16; gj++) begin : g_sbox_col
      assign sbox_tab[gi][gj] = sbox[511-64*gi-4*gj -: 4];
    end
  end

  // Key schedule: forward order for the first 24 (encrypt) or 8 (decrypt)
  // rounds, reversed order afterwards.
  assign round_idx = counter_reg[4:0];
  assign fwd_order = mode_reg ? (round_idx < 5'd8) : (round_idx < 5'd24);
  assign key_idx   = fwd_order ? round_idx[2:0] : ~round_idx[2:0];
  assign round_key = subkey[key_idx];

  // Round function: add key, substitute each nibble, rotate left by 11.
  assign sum_word = n1_reg + round_key;

  for (genvar gi = 0; gi < 8; gi++) begin : g_subst
    assign sub_word[4*gi +: 4] = sbox_tab[gi][sum_word[4*gi +: 4]];
  end

  assign f_word = {sub_word[20:0], sub_word[31:21]};

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    n1_next      = n1_reg;
    n2_next      = n2_reg;
    mode_next    = mode_reg;
    out_next     = out_reg;

    if (load_data) begin
      // A load wins over reset and over an operation already in flight.
      n1_next      = in[63:32];
      n2_next      = in[31:0];
      mode_next    = mode;
      counter_next = 6'd0;
      state_next   = ST_RUN;
      if (reset) begin
        out_next = 64'd0;
      end
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (counter_reg == 6'd32) begin
            out_next   = {n2_reg, n1_reg};
            state_next = ST_IDLE;
          end else begin
            n1_next      = n2_reg ^ f_word;
            n2_next      = n1_reg;
            counter_next = counter_reg + 6'd1;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !load_data) begin
      state_reg   <= ST_IDLE;
      counter_reg <= 6'd0;
      out_reg     <= 64'd0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      n1_reg      <= n1_next;
      n2_reg      <= n2_next;
      mode_reg    <= mode_next;
      out_reg     <= out_next;
    end
  end

  assign out  = out_reg;
  assign busy = (state_reg == ST_RUN);

endmodule

// File: tb/tb_gost89_ecb_engine.sv
// Self-checking bench for gost89_ecb_engine: directed vectors plus randomized
// loads, aborts and resets, checked every cycle against a behavioural model.
module tb_gost89_ecb_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic         load_data;
  logic [511:0] sbox;
  logic [255:0] key;
  logic [63:0]  din;
  logic [63:0]  dout;
  logic         busy;

  int errors = 0;
  int checks = 0;

  // behavioural expectation state
  logic        exp_busy;
  logic [63:0] exp_out;
  logic [63:0] pend;
  int          cnt;

  gost89_ecb_engine dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .load_data (load_data),
    .sbox      (sbox),
    .key       (key),
    .in        (din),
    .out       (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Whole-block reference computed directly from the cipher definition.
  function automatic logic [63:0] gost_ref(input logic [63:0] blk, input logic dec);
    logic [31:0] a, b, t, s, k, f, tmp;
    int ki, nib;
    a = blk[63:32];
    b = blk[31:0];
    for (int r = 0; r < 32; r++) begin
      if (!dec) ki = (r < 24) ? (r % 8) : (7 - (r % 8));
      else      ki = (r < 8)  ? r       : (7 - (r % 8));
      k = 32'((key >> (224 - 32 * ki)) & 256'hffffffff);
      t = a + k;
      s = 32'd0;
      for (int j = 0; j < 8; j++) begin
        nib = int'((t >> (4 * j)) & 32'hf);
        s = s | (32'((sbox >> (508 - 64 * j - 4 * nib)) & 512'hf) << (4 * j));
      end
      f = (s << 11) | (s >> 21);
      tmp = a;
      a = b ^ f;
      b = tmp;
    end
    return {b, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
    end
  endtask

  // One clock edge; update the expected state from the sampled inputs, then compare.
  task automatic tick();
    @(posedge clk);
    #1;
    if (load_data) begin
      exp_busy = 1'b1;
      cnt      = 0;
      pend     = gost_ref(din, mode);
      if (reset) exp_out = 64'd0;
    end else if (reset) begin
      exp_busy = 1'b0;
      exp_out  = 64'd0;
    end else if (exp_busy) begin
      cnt++;
      if (cnt == 33) begin
        exp_busy = 1'b0;
        exp_out  = pend;
      end
    end
    check("busy", {63'd0, busy}, {63'd0, exp_busy});
    check("out", dout, exp_out);
  endtask

  // Full operation; reports the result and the number of busy cycles.
  task automatic run_op(input logic [63:0] blk, input logic m,
                        output logic [63:0] res, output int busy_cycles);
    int guard;
    din = blk;
    mode = m;
    load_data = 1'b1;
    tick();
    load_data = 1'b0;
    busy_cycles = busy ? 1 : 0;
    guard = 0;
    while (busy && guard < 40) begin
      tick();
      if (busy) busy_cycles++;
      guard++;
    end
    if (guard >= 40) check("op_timeout", 64'(guard), 64'd33);
    res = dout;
    $display("op mode=%0d in=%h out=%h busy_cycles=%0d", m, blk, res, busy_cycles);
  endtask

  task automatic directed(input string tag, input logic [63:0] blk, input logic m,
                          input logic [63:0] want);
    logic [63:0] res;
    int bc;
    run_op(blk, m, res, bc);
    check(tag, res, want);
    check({tag, "_busy_len"}, 64'(bc), 64'd33);
  endtask

  initial begin
    logic [63:0] res;
    int bc;
    int wait_n;
    logic [63:0] blk;

    sbox = 512'h4a92d80e6b1c7f53eb4c6dfa23810759581da342efc7609b7da1089fe46cb2536c715fd84a9e03b24ba0721d36859cfedb413f590ae7682c1fd057a4923e6b8c;
    key  = 256'h0475f6e05038fbfad2c7c390edb3ca3d1547124291ae1e8a2f79cd9ed2bcefbd;
    din = 64'd0;
    mode = 1'b0;
    load_data = 1'b0;
    reset = 1'b1;
    exp_busy = 1'b0;
    exp_out = 64'd0;
    pend = 64'd0;
    cnt = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    directed("enc_a", 64'hd5a8a608f4f115b4, 1'b0, 64'hd658a36b11cf46eb);
    directed("dec_a", 64'hd658a36b11cf46eb, 1'b1, 64'hd5a8a608f4f115b4);

    reset = 1'b1; tick(); reset = 1'b0; tick();
    directed("enc_b", 64'h389eb44a391474c4, 1'b0, 64'h7aea1ed18e604249);
    directed("dec_b", 64'h7aea1ed18e604249, 1'b1, 64'h389eb44a391474c4);

    // abort by reset 7 clocks after a load
    din = 64'h0123456789abcdef; mode = 1'b0; load_data = 1'b1; tick(); load_data = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_out", dout, 64'd0);
    tick();
    directed("enc_c", 64'h379e59c3c96bb2ab, 1'b0, 64'hc35472c91cd78640);
    directed("dec_c", 64'hc35472c91cd78640, 1'b1, 64'h379e59c3c96bb2ab);

    // load and reset on the same edge
    reset = 1'b1;
    din = 64'h3f38ae3b8f541361; mode = 1'b0; load_data = 1'b1; tick();
    reset = 1'b0; load_data = 1'b0;
    check("ldrst_out", dout, 64'd0);
    check("ldrst_busy", {63'd0, busy}, 64'd1);
    wait_n = 0;
    while (busy && wait_n < 40) begin tick(); wait_n++; end
    check("ldrst_len", 64'(wait_n), 64'd33);
    check("ldrst_enc", dout, 64'h3b5834a000fba066);
    directed("ldrst_dec", 64'h3b5834a000fba066, 1'b1, 64'h3f38ae3b8f541361);

    // randomized traffic: full ops, aborting reloads, resets and load+reset
    for (int it = 0; it < 40; it++) begin
      blk = {$urandom, $urandom};
      if (it == 20) begin
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        $display("new random key=%h", key);
      end
      case ($urandom_range(0, 3))
        0: begin
          run_op(blk, 1'($urandom), res, bc);
          check("rnd_len", 64'(bc), 64'd33);
          run_op(res, ~mode, res, bc);
          check("rnd_roundtrip", res, blk);
        end
        1: begin
          din = blk; mode = 1'($urandom); load_data = 1'b1; tick(); load_data = 1'b0;
          wait_n = $urandom_range(1, 34);
          for (int i = 0; i < wait_n; i++) tick();
          $display("reload after %0d cycles", wait_n);
          run_op({$urandom, $urandom}, 1'($urandom), res, bc);
        end
        2: begin
          din = blk; mode = 1'($urandom); load_data = 1'b1; tick(); load_data = 1'b0;
          wait_n = $urandom_range(1, 34);
          for (int i = 0; i < wait_n; i++) tick();
          reset = 1'b1; tick(); reset = 1'b0;
          $display("reset after %0d cycles", wait_n);
          tick();
        end
        default: begin
          reset = 1'b1; din = blk; mode = 1'($urandom); load_data = 1'b1; tick();
          reset = 1'b0; load_data = 1'b0;
          for (int i = 0; i < 35; i++) tick();
          $display("load+reset in=%h out=%h", blk, dout);
        end
      endcase
    end

    for (int i = 0; i < 3; i++) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
